// File: rtl/obstacle_spawner.sv
// Obstacle spawner: requests a packed batch of random numbers, then turns each
// number into an obstacle type plus a spawn gap measured in game-frame ticks.
module obstacle_spawner #(
    parameter int unsigned NUM_LEN   = 4,
    parameter int unsigned NUM_COUNT = 4,
    parameter int unsigned MIN_GAP   = 8
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  logic                         tick_i,
    input  logic                         bird_en_i,
    input  logic [NUM_LEN*NUM_COUNT-1:0] randoms_i,
    output logic                         start_o,
    output logic                         spawn_o,
    output logic [1:0]                   spawn_type_o,
    output logic [15:0]                  spawn_count_o
);

    localparam int unsigned IdxW = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;

    typedef enum logic [2:0] {StIdle, StRequest, StLoad, StWait, StSpawn} state_e;

    state_e                       state_q;
    logic [NUM_LEN*NUM_COUNT-1:0] buf_q;
    logic [IdxW-1:0]              idx_q;
    logic [7:0]                   gap_cnt_q;
    logic                         start_q;
    logic                         spawn_q;
    logic [1:0]                   type_q;
    logic [15:0]                  count_q;

    logic [NUM_LEN-1:0] cur_num;
    logic [NUM_LEN-1:0] nxt_num;
    logic [IdxW-1:0]    idx_nxt;

    function automatic logic [7:0] gap_of(input logic [NUM_LEN-1:0] n);
        return 8'(MIN_GAP) + 8'(n[NUM_LEN-1:2]);
    endfunction

    function automatic logic [1:0] type_of(input logic [NUM_LEN-1:0] n, input logic bird_en);
        logic [1:0] t;
        t = n[1:0];
        if (!bird_en && t == 2'd3) begin
            t = 2'd0;
        end
        return t;
    endfunction

    // nxt_num is only consumed while idx_q < NUM_COUNT-1, so any wrap is harmless
    always_comb begin
        idx_nxt = idx_q + 1'b1;
        cur_num = buf_q[idx_q*NUM_LEN +: NUM_LEN];
        nxt_num = buf_q[idx_nxt*NUM_LEN +: NUM_LEN];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            buf_q     <= '0;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            start_q   <= 1'b0;
            spawn_q   <= 1'b0;
            type_q    <= 2'd0;
            count_q   <= 16'd0;
        end else begin
            start_q <= 1'b0;
            spawn_q <= 1'b0;
            if (clear_i && state_q != StIdle) begin
                state_q   <= StRequest;
                start_q   <= 1'b1;
                buf_q     <= '0;
                idx_q     <= '0;
                gap_cnt_q <= '0;
                count_q   <= 16'd0;
            end else begin
                if (clear_i) begin
                    count_q <= 16'd0;
                end
                unique case (state_q)
                    StIdle: begin
                        if (enable_i) begin
                            state_q <= StRequest;
                            start_q <= 1'b1;
                        end
                    end
                    StRequest: state_q <= StLoad;
                    StLoad: begin
                        buf_q     <= randoms_i;
                        idx_q     <= '0;
                        gap_cnt_q <= gap_of(randoms_i[NUM_LEN-1:0]);
                        state_q   <= StWait;
                    end
                    StWait: begin
                        if (tick_i && enable_i) begin
                            gap_cnt_q <= gap_cnt_q - 8'd1;
                            if (gap_cnt_q == 8'd1) begin
                                state_q <= StSpawn;
                                spawn_q <= 1'b1;
                                type_q  <= type_of(cur_num, bird_en_i);
                                if (count_q != 16'hFFFF) begin
                                    count_q <= count_q + 16'd1;
                                end
                            end
                        end
                    end
                    StSpawn: begin
                        if (32'(idx_q) < NUM_COUNT - 1) begin
                            idx_q     <= idx_nxt;
                            gap_cnt_q <= gap_of(nxt_num);
                            state_q   <= StWait;
                        end else begin
                            state_q <= StRequest;
                            start_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign start_o       = start_q;
    assign spawn_o       = spawn_q;
    assign spawn_type_o  = type_q;
    assign spawn_count_o = count_q;

endmodule
